// File: rtl/led_mmio.sv
// led_mmio: memory-mapped LED output peripheral on the cpu data bus.
// Register window of 16 bytes at BASE_ADDR: DATA (+0x0), BLINK (+0x4),
// DIV (+0x8) and, when LED_MMIO_PWM_EN is defined, BRIGHT (+0xC).
// A prescaler toggles a blink phase every DIV cycles; blinking LEDs are
// on during phase 0 and off during phase 1. The LED pins are registered.
// Optional feature macro: LED_MMIO_PWM_EN (adds BRIGHT and a PWM gate).
module led_mmio #(
    parameter logic [31:0]      BASE_ADDR = 32'hFFFF_0000,
    parameter int               DIV_W     = 24,
    parameter logic [DIV_W-1:0] DIV_RST   = 24'd12_500_000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        led0,
    output logic        led1,
    output logic        led2,
    output logic        led3,
    output logic        led4,
    output logic        led5,
    output logic        led6,
    output logic        led7
);

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [31:0]      offset_s;
    logic [1:0]       word_s;
    logic             wr_s;
    logic             wdata_unused_s;
    logic [7:0]       data_r;
    logic [7:0]       blink_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_eff_s;
    logic             wrap_s;
    logic             phase_r;
    logic             gate_s;
    logic [7:0]       led_next_s;
    logic [7:0]       led_r;
`ifdef LED_MMIO_PWM_EN
    logic [7:0]       bright_r;
    logic [7:0]       pwm_r;
`endif

    // Address decode: offset from the base so the window need not be 16-byte aligned.
    always_comb begin
        offset_s       = addr - BASE_ADDR;
        sel            = (offset_s < 32'd16);
        word_s         = offset_s[3:2];
        wr_s           = we & sel;
        wdata_unused_s = ^wdata;
    end

    // Effective half-period (DIV of 0 behaves like 1) and wrap detect.
    always_comb begin
        if (div_r == {DIV_W{1'b0}}) begin
            div_eff_s = DIV_ONE;
        end else begin
            div_eff_s = div_r;
        end
        wrap_s = (cnt_r >= (div_eff_s - DIV_ONE));
    end

    // Brightness gate and next LED value from the current register state.
    always_comb begin
`ifdef LED_MMIO_PWM_EN
        gate_s = (bright_r == 8'hFF) | (pwm_r < bright_r);
`else
        gate_s = 1'b1;
`endif
        led_next_s = data_r & ~(blink_r & {8{phase_r}}) & {8{gate_s}};
    end

    // Read mux: zero-extended register contents, 0 outside the window.
    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (word_s)
                2'd0:    rdata = {24'd0, data_r};
                2'd1:    rdata = {24'd0, blink_r};
                2'd2:    rdata = {{(32-DIV_W){1'b0}}, div_r};
`ifdef LED_MMIO_PWM_EN
                2'd3:    rdata = {24'd0, bright_r};
`else
                2'd3:    rdata = 32'd0;
`endif
                default: rdata = 32'd0;
            endcase
        end else begin
            rdata = 32'd0;
        end
    end

    // Software-visible registers, updated by stores that hit the window.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            data_r   <= 8'd0;
            blink_r  <= 8'd0;
            div_r    <= DIV_RST;
`ifdef LED_MMIO_PWM_EN
            bright_r <= 8'hFF;
`endif
        end else if (wr_s) begin
            case (word_s)
                2'd0:    data_r   <= wdata[7:0];
                2'd1:    blink_r  <= wdata[7:0];
                2'd2:    div_r    <= wdata[DIV_W-1:0];
`ifdef LED_MMIO_PWM_EN
                2'd3:    bright_r <= wdata[7:0];
`endif
                default: data_r   <= data_r;
            endcase
        end
    end

    // Blink prescaler: a DIV store restarts the count without touching phase.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_r   <= {DIV_W{1'b0}};
            phase_r <= 1'b0;
        end else if (wr_s && (word_s == 2'd2)) begin
            cnt_r   <= {DIV_W{1'b0}};
        end else if (wrap_s) begin
            cnt_r   <= {DIV_W{1'b0}};
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + DIV_ONE;
        end
    end

`ifdef LED_MMIO_PWM_EN
    // Free-running PWM counter, wraps 255 -> 0.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            pwm_r <= 8'd0;
        end else begin
            pwm_r <= pwm_r + 8'd1;
        end
    end
`endif

    // Registered LED drive.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            led_r <= 8'd0;
        end else begin
            led_r <= led_next_s;
        end
    end

    assign led0 = led_r[0];
    assign led1 = led_r[1];
    assign led2 = led_r[2];
    assign led3 = led_r[3];
    assign led4 = led_r[4];
    assign led5 = led_r[5];
    assign led6 = led_r[6];
    assign led7 = led_r[7];

endmodule
